// File: rtl/mul_sequencer_pkg.sv
// Shared encodings for the multicycle multiply sequencer and the ALU decoder path.
package mul_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // Flag write-enable mask {N/Z, C/V}: a multiply only ever touches N and Z.
  localparam logic [1:0] FLAGW_NONE = 2'b00;
  localparam logic [1:0] FLAGW_NZ   = 2'b10;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand/multiplier, step counter.
module mul_shift_add_dp #(
  parameter int WIDTH     = 32,
  parameter int SKIP_ZERO = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] acc_init,
  input  logic [WIDTH-1:0] mcand_init,
  input  logic [WIDTH-1:0] mplier_init,
  output logic [WIDTH-1:0] acc_next,
  output logic             last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum;

  assign sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign acc_next = sum;

  // The step in progress is the final one when the counter is at its last
  // value, or (early exit) when no set multiplier bits remain after the shift.
  assign last = (cnt_q == CNT_LAST) ||
                ((SKIP_ZERO != 0) && (mplier_q[WIDTH-1:1] == '0));

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = acc_init;
      mcand_d  = mcand_init;
      mplier_d = mplier_init;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// MUL/MLA control FSM: accepts a Start, steps the shift-add datapath, presents Result/Flags.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SKIP_ZERO = 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Accumulate,
  input  logic             SetFlags,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] SrcAcc,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [1:0]       Flags,
  output logic [1:0]       FlagW
);

  mul_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sf_q, sf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       flags_q, flags_d;
  logic [1:0]       flagw_q, flagw_d;

  logic             dp_load, dp_step, dp_last;
  logic [WIDTH-1:0] dp_acc_next;

  mul_shift_add_dp #(
    .WIDTH    (WIDTH),
    .SKIP_ZERO(SKIP_ZERO)
  ) u_dp (
    .clk        (clk),
    .srst       (Reset),
    .load       (dp_load),
    .step       (dp_step),
    .acc_init   (Accumulate ? SrcAcc : '0),
    .mcand_init (SrcA),
    .mplier_init(SrcB),
    .acc_next   (dp_acc_next),
    .last       (dp_last)
  );

  always_comb begin
    state_d  = state_q;
    sf_d     = sf_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    flagw_d  = FLAGW_NONE;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          dp_load = 1'b1;
          sf_d    = SetFlags;
        end
      end
      ST_RUN: begin
        dp_step = 1'b1;
        // Result is captured from the final step's sum so it is valid in DONE.
        if (dp_last) begin
          state_d  = ST_DONE;
          result_d = dp_acc_next;
          flags_d  = {dp_acc_next[WIDTH-1], dp_acc_next == '0};
          done_d   = 1'b1;
          flagw_d  = sf_q ? FLAGW_NZ : FLAGW_NONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sf_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= 2'b00;
      flagw_q  <= FLAGW_NONE;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sf_q     <= sf_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      flagw_q  <= flagw_d;
    end
  end

  assign Ready  = ready_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign Flags  = flags_q;
  assign FlagW  = flagw_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized and directed checks of mul_sequencer (early-exit and full-length builds) against an arithmetic model.
module tb_mul_sequencer;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, accum, setf;
  logic [W-1:0] a, b, c;

  logic         s_ready, s_busy, s_done, f_ready, f_busy, f_done;
  logic [W-1:0] s_result, f_result;
  logic [1:0]   s_flags, s_flagw, f_flags, f_flagw;

  mul_sequencer #(.WIDTH(W), .SKIP_ZERO(1)) u_dut_skip (
    .clk(clk), .Reset(rst), .Start(start), .Accumulate(accum), .SetFlags(setf),
    .SrcA(a), .SrcB(b), .SrcAcc(c),
    .Ready(s_ready), .Busy(s_busy), .Done(s_done),
    .Result(s_result), .Flags(s_flags), .FlagW(s_flagw)
  );

  mul_sequencer #(.WIDTH(W), .SKIP_ZERO(0)) u_dut_full (
    .clk(clk), .Reset(rst), .Start(start), .Accumulate(accum), .SetFlags(setf),
    .SrcA(a), .SrcB(b), .SrcAcc(c),
    .Ready(f_ready), .Busy(f_busy), .Done(f_done),
    .Result(f_result), .Flags(f_flags), .FlagW(f_flagw)
  );

  // Outputs of whichever build the current operation observes.
  bit           sel;
  logic         m_ready, m_busy, m_done;
  logic [W-1:0] m_result;
  logic [1:0]   m_flags, m_flagw;
  assign m_ready  = sel ? f_ready  : s_ready;
  assign m_busy   = sel ? f_busy   : s_busy;
  assign m_done   = sel ? f_done   : s_done;
  assign m_result = sel ? f_result : s_result;
  assign m_flags  = sel ? f_flags  : s_flags;
  assign m_flagw  = sel ? f_flagw  : s_flagw;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] prev_result = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int run_len(input logic [W-1:0] m, input bit skip);
    int n = 1;
    if (!skip) return W;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return n;
  endfunction

  task automatic wait_both_idle();
    int k = 0;
    while (!(s_ready && f_ready) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("both_idle", 64'(s_ready && f_ready), 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W-1:0] tc,
                        input bit tacc, input bit tsf, input bit tsel, input string tag);
    logic [63:0] prod;
    logic [W-1:0] exp_r;
    int n, cycles, busy_cnt;
    bit seen;
    sel   = tsel;
    prod  = 64'(ta) * 64'(tb_v) + (tacc ? 64'(tc) : 64'd0);
    exp_r = prod[W-1:0];
    n     = run_len(tb_v, !tsel);
    @(posedge clk); #1;
    a = ta; b = tb_v; c = tc; accum = tacc; setf = tsf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; c = $urandom; accum = 1'($urandom); setf = 1'($urandom);
    cycles = 1; seen = 0; busy_cnt = 0;
    while (!seen && cycles <= 40) begin
      @(negedge clk);
      if (cycles == 1) check({tag, "_held"}, 64'(m_result), 64'(prev_result));
      if (m_done) seen = 1;
      else begin
        if (m_busy) busy_cnt++;
        cycles++;
        @(posedge clk);
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_done_cycle"}, 64'(cycles), 64'(n + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
    check({tag, "_result"}, 64'(m_result), 64'(exp_r));
    check({tag, "_flags"}, 64'(m_flags), 64'({exp_r[W-1], exp_r == '0}));
    check({tag, "_flagw"}, 64'(m_flagw), tsf ? 64'd2 : 64'd0);
    @(negedge clk);
    check({tag, "_ready_after"}, 64'({m_ready, m_done, m_flagw}), 64'b1000);
    check({tag, "_result_kept"}, 64'(m_result), 64'(exp_r));
    $display("op %s sel=%0d a=%h b=%h acc=%h mla=%0d s=%0d -> result=%h n=%0d", tag, tsel, ta, tb_v, tc,
             tacc, tsf, m_result, n);
    prev_result = exp_r;
    wait_both_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; accum = 1'b0; setf = 1'b0; a = '0; b = '0; c = '0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({s_ready, s_busy, s_done, s_flags, s_flagw}), 64'b1000000);
    check("reset_result", 64'(s_result), 64'd0);
    check("reset_state_full", 64'({f_ready, f_busy, f_done, f_flags, f_flagw}), 64'b1000000);
    @(posedge clk); #1; rst = 1'b0;

    run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 1'b0, "mul_7x6");
    run_op(32'h8000_0000, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0, "mla_neg");
    run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 1'b0, "wrap");
    run_op(32'd123, 32'd0, 32'd5, 1'b1, 1'b0, 1'b0, "zero_mplier");
    run_op(32'd3, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, "full_len");

    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] ra, rb, rc;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      rc = $urandom;
      run_op(ra, rb, rc, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    // Start arriving during DONE (early-exit build) must not launch a new run.
    sel = 0;
    @(posedge clk); #1; a = 32'd9; b = 32'd1; c = '0; accum = 1'b0; setf = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("start_in_done_ignored", 64'({s_ready, s_busy}), 64'b10);
    check("start_in_done_result", 64'(s_result), 64'd9);
    $display("op start_in_done ready=%0d busy=%0d result=%h", s_ready, s_busy, s_result);
    prev_result = 32'd9;
    wait_both_idle();

    // Abort: a second Start during RUN is ignored, then Reset mid-run discards everything.
    @(posedge clk); #1; a = 32'd3; b = 32'h0000_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; a = 32'd2; b = 32'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("second_start_ignored", 64'({s_ready, s_busy}), 64'b01);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'({s_ready, s_busy, s_done, f_ready, f_busy, f_done}), 64'b100100);
    check("abort_result", 64'({s_result, f_result}), 64'd0);
    check("abort_flags", 64'({s_flags, s_flagw, f_flags, f_flagw}), 64'd0);
    begin
      int dones = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (s_done || f_done) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
    end
    $display("op abort ready=%0d busy=%0d result=%h", s_ready, s_busy, s_result);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Iterative shift-add multiply controller for the multicycle ARM core. It handles MUL/MLA, producing the low 32 bits, over several cycles. The main FSM pulses Start and holds its execute state while Busy is high, then takes Result on Done. The sequencer owns its own datapath registers and adds no area to the single-cycle ALU.

Parameters:
WIDTH, 32, operand and result width in bits
SKIP_ZERO, 1, when 1 the run ends early once the remaining multiplier bits are all zero

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request pulse; accepted only when Ready=1
Accumulate  input  1  sampled with Start; 1 = MLA (add SrcAcc), 0 = MUL
SetFlags  input  1  sampled with Start; S bit of the instruction
SrcA  input  WIDTH  multiplicand, sampled with Start
SrcB  input  WIDTH  multiplier, sampled with Start
SrcAcc  input  WIDTH  accumulate operand, sampled with Start
Ready  output  1  high in IDLE
Busy  output  1  high in RUN
Done  output  1  one-cycle pulse in DONE
Result  output  WIDTH  product mod 2^WIDTH; held stable from DONE until the next accepted Start
Flags  output  2  {N,Z} of Result, valid from DONE onward
FlagW  output  2  2'b10 during DONE if SetFlags was latched, else 2'b00 (C,V untouched)

Behaviour:
- Reset (synchronous, active-high): state=IDLE, Result=0, Flags=0, Busy=0, Done=0, FlagW=0, Ready=1. Reset overrides every other input in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when Start=1 at a clock edge.
  - Latch acc = Accumulate ? SrcAcc : 0, mcand=SrcA, mplier=SrcB, cnt=0.
  - Latch the SetFlags and Accumulate values.
- RUN, every cycle:
  - If mplier[0], acc = acc + mcand, wrapped mod 2^WIDTH.
  - mcand <<= 1, mplier >>= 1, cnt++.
- RUN -> DONE after the RUN cycle in which cnt reaches WIDTH-1, or earlier if SKIP_ZERO=1 and the shifted mplier is 0.
- RUN length n:
  - SKIP_ZERO=0: n = WIDTH.
  - SKIP_ZERO=1: n = max(1, index of the highest set bit of SrcB + 1).
  - SrcB=0 gives n=1.
- DONE:
  - Result=acc, Flags={acc[WIDTH-1], acc==0}, Done=1, FlagW as above.
  - Unconditional return to IDLE next cycle.
- Latency: Start high in cycle 0 -> Busy high in cycles 1..n -> Done high in cycle n+1 -> Ready high in cycle n+2.
- Start while state is not IDLE (RUN or DONE) is ignored. No queueing, no error.
- Operand inputs are don't-care except in the Start cycle.
- Result and Flags update only on entry to DONE or on Reset. During RUN they still hold the previous result.
- Reset mid-RUN: operation discarded, no Done pulse, outputs return to reset values next cycle.
- Signed and unsigned low-word products are identical; no signedness input.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the FlagW encodings (FLAGW_NONE=2'b00, FLAGW_NZ=2'b10), reused by the ALU decoder path.
- One sub-module, mul_shift_add_dp, holding the acc/mcand/mplier/cnt registers, the adder and the zero-detect. It takes load/step controls from the FSM in mul_sequencer.

Test Plan:
- Reset: Reset=1 for 2 cycles -> Ready=1, Busy=0, Done=0, Result=0, Flags=0, FlagW=0.
- MUL, SKIP_ZERO=1: SrcA=7, SrcB=6, Accumulate=0, SetFlags=0, Start in cycle 0 -> Busy in cycles 1-3, Done in cycle 4, Result=42, Flags=00, FlagW=00.
- MLA with flags: SrcA=0x80000000, SrcB=1, SrcAcc=0, SetFlags=1 -> n=1, Done in cycle 2, Result=0x80000000, Flags N=1 Z=0, FlagW=10.
- Wrap-around: SrcA=0x00010000, SrcB=0x00010000, SetFlags=1 -> n=17, Done in cycle 18, Result=0, Z=1.
- Zero multiplier: SrcB=0, Accumulate=1, SrcAcc=5 -> n=1, Result=5.
- SKIP_ZERO=0: SrcA=3, SrcB=1 -> Done in cycle 33, Result=3.
- Abort and ignored Start: Start, then a second Start in cycle 2 -> second Start ignored. Reset in cycle 3 -> cycle 4 IDLE, no Done ever, Result=0.
